// File: rtl/escalonador_cargas.sv
// Power-budget scheduler: grants up to MAX_ATIVAS zone loads in round-robin order,
// with grants spaced at least INTERVALO_PARTIDA cycles apart to limit inrush current.
module escalonador_cargas #(
    parameter int unsigned N_ZONAS           = 4,
    parameter int unsigned MAX_ATIVAS        = 2,
    parameter int unsigned INTERVALO_PARTIDA = 100
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_ZONAS-1:0]               pedido,
    input  logic                             desligar_tudo,
    output logic [N_ZONAS-1:0]               concessao,
    output logic [N_ZONAS-1:0]               aguardando,
    output logic [$clog2(N_ZONAS+1)-1:0]     qtd_ativas,
    output logic                             ocupado
);
    localparam int unsigned QW = $clog2(N_ZONAS + 1);
    localparam int unsigned PW = $clog2(N_ZONAS);
    localparam int unsigned CW = $clog2(INTERVALO_PARTIDA) + 1;

    typedef enum logic [0:0] {
        LIVRE     = 1'b0,
        INTERVALO = 1'b1
    } estado_t;

    localparam logic [CW-1:0] RECARGA = CW'(INTERVALO_PARTIDA - 1);
    // With a 1-cycle interval the scheduler never leaves LIVRE, allowing back-to-back grants.
    localparam estado_t APOS_CONCESSAO = (INTERVALO_PARTIDA > 1) ? INTERVALO : LIVRE;

    estado_t             estado_q, estado_d;
    logic [CW-1:0]       contador_q, contador_d;
    logic [PW-1:0]       ponteiro_q, ponteiro_d;
    logic [N_ZONAS-1:0]  concessao_q, concessao_d;
    logic [QW-1:0]       qtd_q, qtd_d;
    logic                ocupado_q, ocupado_d;

    logic [N_ZONAS-1:0]  mantidos;
    logic [N_ZONAS-1:0]  candidatos;
    logic [QW-1:0]       ativos_mantidos;
    logic [PW-1:0]       idx;
    logic [PW-1:0]       vencedor;
    logic                achou;
    logic                pode_conceder;

    function automatic logic [QW-1:0] contar(input logic [N_ZONAS-1:0] v);
        logic [QW-1:0] s;
        s = '0;
        for (int i = 0; i < int'(N_ZONAS); i++) begin
            s = s + QW'(v[i]);
        end
        return s;
    endfunction

    // Next-state: releases, round-robin winner search, grant and inter-grant spacing.
    always_comb begin
        mantidos        = concessao_q & pedido;
        candidatos      = pedido & ~concessao_q;
        ativos_mantidos = contar(mantidos);
        achou           = 1'b0;
        vencedor        = '0;
        idx             = '0;
        estado_d        = estado_q;
        contador_d      = contador_q;
        ponteiro_d      = ponteiro_q;
        concessao_d     = mantidos;

        for (int unsigned k = 0; k < N_ZONAS; k++) begin
            idx = PW'((32'(ponteiro_q) + k) % N_ZONAS);
            if (!achou && candidatos[idx]) begin
                achou    = 1'b1;
                vencedor = idx;
            end
        end

        pode_conceder = (estado_q == LIVRE) && !desligar_tudo && achou
                        && (ativos_mantidos < QW'(MAX_ATIVAS));

        if (desligar_tudo) begin
            concessao_d = '0;
            contador_d  = RECARGA;
            estado_d    = APOS_CONCESSAO;
        end else if (pode_conceder) begin
            concessao_d[vencedor] = 1'b1;
            ponteiro_d  = (vencedor == PW'(N_ZONAS - 1)) ? '0 : vencedor + PW'(1);
            contador_d  = RECARGA;
            estado_d    = APOS_CONCESSAO;
        end else if (estado_q == INTERVALO) begin
            contador_d = (contador_q != '0) ? contador_q - CW'(1) : '0;
            if (contador_d == '0) begin
                estado_d = LIVRE;
            end
        end

        qtd_d     = contar(concessao_d);
        ocupado_d = (qtd_d == QW'(MAX_ATIVAS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= LIVRE;
            contador_q  <= '0;
            ponteiro_q  <= '0;
            concessao_q <= '0;
            qtd_q       <= '0;
            ocupado_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            contador_q  <= contador_d;
            ponteiro_q  <= ponteiro_d;
            concessao_q <= concessao_d;
            qtd_q       <= qtd_d;
            ocupado_q   <= ocupado_d;
        end
    end

    assign concessao  = concessao_q;
    assign aguardando = pedido & ~concessao_q;
    assign qtd_ativas = qtd_q;
    assign ocupado    = ocupado_q;

endmodule

// File: tb/tb_escalonador_cargas.sv
// Directed bench for escalonador_cargas (N=4, MAX=2, INTERVALO=100); edges counted from release of reset.
module tb_escalonador_cargas;
    logic       clk;
    logic       rst;
    logic [3:0] pedido;
    logic       desligar_tudo;
    logic [3:0] concessao;
    logic [3:0] aguardando;
    logic [2:0] qtd_ativas;
    logic       ocupado;

    int errors = 0;
    int checks = 0;
    int borda  = 0;

    escalonador_cargas #(
        .N_ZONAS(4),
        .MAX_ATIVAS(2),
        .INTERVALO_PARTIDA(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pedido(pedido),
        .desligar_tudo(desligar_tudo),
        .concessao(concessao),
        .aguardando(aguardando),
        .qtd_ativas(qtd_ativas),
        .ocupado(ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, borda, obs, exp);
        end
    endtask

    // Advance to just after the given edge; inputs driven afterwards are seen at the next edge.
    task automatic ate(input int alvo);
        while (borda < alvo) begin
            @(posedge clk);
            borda++;
        end
        #1;
    endtask

    task automatic estado(input string tag, input logic [3:0] c, input logic [2:0] q, input logic o);
        chk({tag, "_concessao"}, 32'(concessao), 32'(c));
        chk({tag, "_qtd"}, 32'(qtd_ativas), 32'(q));
        chk({tag, "_ocupado"}, 32'(ocupado), 32'(o));
    endtask

    initial begin
        rst = 1'b1;
        pedido = 4'b0000;
        desligar_tudo = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        estado("reset", 4'b0000, 3'd0, 1'b0);
        chk("reset_aguardando", 32'(aguardando), 32'h0);
        pedido = 4'b0101;
        @(posedge clk);
        #1;
        chk("reset_aguardando_segue", 32'(aguardando), 32'h5);
        chk("reset_sem_concessao", 32'(concessao), 32'h0);

        // All zones request: first grant at edge 1, second at edge 101
        borda = 0;
        rst = 1'b0;
        pedido = 4'b1111;
        ate(1);
        estado("e1", 4'b0001, 3'd1, 1'b0);
        chk("e1_aguardando", 32'(aguardando), 32'he);
        ate(100);
        chk("e100_espaco", 32'(concessao), 32'h1);
        ate(101);
        estado("e101", 4'b0011, 3'd2, 1'b1);
        chk("e101_aguardando", 32'(aguardando), 32'hc);
        ate(300);
        estado("e300_estavel", 4'b0011, 3'd2, 1'b1);

        // Release zone 0 and grant zone 2 at the same edge
        pedido = 4'b1110;
        ate(301);
        estado("e301_troca", 4'b0110, 3'd2, 1'b1);

        // Release zone 1, re-request all; next winner must be zone 3 (pointer at 3)
        pedido = 4'b1100;
        ate(302);
        estado("e302_libera", 4'b0100, 3'd1, 1'b0);
        pedido = 4'b1111;
        ate(400);
        chk("e400_espaco", 32'(concessao), 32'h4);
        ate(401);
        estado("e401_rr3", 4'b1100, 3'd2, 1'b1);

        // Round robin continues: 0 then 1
        pedido = 4'b1011;
        ate(402);
        chk("e402_libera2", 32'(concessao), 32'h8);
        pedido = 4'b1111;
        ate(500);
        chk("e500_espaco", 32'(concessao), 32'h8);
        ate(501);
        chk("e501_rr0", 32'(concessao), 32'h9);
        pedido = 4'b0111;
        ate(502);
        chk("e502_libera3", 32'(concessao), 32'h1);
        pedido = 4'b1111;
        ate(601);
        estado("e601_rr1", 4'b0011, 3'd2, 1'b1);

        // Withdrawal: zone 3 pulses for 50 cycles while full; never granted
        pedido = 4'b0011;
        ate(710);
        chk("e710_aguardando", 32'(aguardando), 32'h0);
        pedido = 4'b1011;
        for (int i = 711; i <= 760; i++) begin
            ate(i);
            chk("retirada_concessao", 32'(concessao), 32'h3);
            chk("retirada_aguardando", 32'(aguardando), 32'h8);
        end
        pedido = 4'b0011;
        ate(761);
        chk("e761_aguardando", 32'(aguardando), 32'h0);
        estado("e761", 4'b0011, 3'd2, 1'b1);
        pedido = 4'b1110;
        ate(762);
        estado("e762_rr2", 4'b0110, 3'd2, 1'b1);

        // Global shutdown pulse, then staggered restart from pointer 3
        pedido = 4'b1111;
        ate(869);
        desligar_tudo = 1'b1;
        ate(870);
        estado("e870_desliga", 4'b0000, 3'd0, 1'b0);
        chk("e870_aguardando", 32'(aguardando), 32'hf);
        desligar_tudo = 1'b0;
        ate(969);
        chk("e969_espera", 32'(concessao), 32'h0);
        ate(970);
        estado("e970_regrant", 4'b1000, 3'd1, 1'b0);
        ate(1069);
        chk("e1069_espaco", 32'(concessao), 32'h8);
        ate(1070);
        estado("e1070_regrant", 4'b1001, 3'd2, 1'b1);

        // Reset mid-operation: clear, then immediate regrant from pointer 0
        ate(1079);
        rst = 1'b1;
        ate(1080);
        estado("e1080_rst", 4'b0000, 3'd0, 1'b0);
        rst = 1'b0;
        ate(1081);
        estado("e1081_pos_rst", 4'b0001, 3'd1, 1'b0);
        ate(1180);
        chk("e1180_espaco", 32'(concessao), 32'h1);
        ate(1181);
        estado("e1181", 4'b0011, 3'd2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/escalonador_cargas.md
Name: escalonador_cargas

Overview:
Power-budget scheduler placed between N lamp controllers (`controladora` instances, one per zone) and the physical load drivers. Each controller's lamp output (`saida`) is treated as a power request. The block grants at most MAX_ATIVAS simultaneous loads, picks among waiting zones in round-robin order, and staggers turn-ons by at least INTERVALO_PARTIDA cycles to limit inrush current. It also provides a global shutdown input.

Parameters:
- N_ZONAS, 4: number of requesting zones (≥2).
- MAX_ATIVAS, 2: maximum simultaneously powered zones (1 ≤ MAX_ATIVAS ≤ N_ZONAS).
- INTERVALO_PARTIDA, 100: minimum cycles between two successive grants (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pedido  in  N_ZONAS  per-zone power request; level, driven from each controller's `saida`.
- desligar_tudo  in  1  global shutdown; level, synchronous.
- concessao  out  N_ZONAS  registered per-zone load enable.
- aguardando  out  N_ZONAS  combinational, equals pedido & ~concessao.
- qtd_ativas  out  $clog2(N_ZONAS+1)  registered popcount of concessao.
- ocupado  out  1  registered, high when qtd_ativas == MAX_ATIVAS.

Behaviour:
- Reset (rst high at an edge): concessao=0, qtd_ativas=0, ocupado=0, ponteiro=0, contador=0, state LIVRE. aguardando then follows pedido. Reset mid-operation drops all grants at that edge.
- FSM has two states:
  - LIVRE: contador==0; a grant is permitted.
  - INTERVALO: contador>0; no grant. contador decrements every cycle; on reaching 0 the next state is LIVRE.
- Release: if pedido[i]==0 and concessao[i]==1 at an edge, concessao[i] clears at that edge. Releases are not rate-limited.
- Slot accounting: slots freed by releases in a cycle are usable by a grant in the same cycle. Free slots = MAX_ATIVAS − (qtd_ativas − releases this cycle).
- Grant: at most one per edge. Conditions:
  - state LIVRE;
  - desligar_tudo==0;
  - free slots > 0;
  - at least one bit of pedido & ~concessao is set.
- Winner is the first set candidate bit searching from index ponteiro upward, wrapping from N_ZONAS−1 to 0.
- On a grant:
  - concessao[w] sets;
  - ponteiro ← (w+1) mod N_ZONAS;
  - contador ← INTERVALO_PARTIDA−1;
  - state → INTERVALO, or stays LIVRE when INTERVALO_PARTIDA==1, which allows back-to-back grants.
- Latency: pedido rising at edge k while all grant conditions hold gives concessao high after edge k+1. A 1-cycle request pulse that is granted stays granted until pedido is seen low at a later edge (release happens 1 cycle after pedido falls).
- Withdrawn request: a pending zone whose pedido drops is never granted. ponteiro does not change.
- desligar_tudo high at an edge:
  - concessao clears entirely;
  - no grants are issued;
  - contador loads INTERVALO_PARTIDA−1 (INTERVALO state).
  - Restart after deassertion is therefore staggered.
- Simultaneous release and grant of the same zone is impossible: a released zone has pedido=0.
- qtd_ativas and ocupado are updated at the same edge as concessao, consistent with its next value.
- Counter width is $clog2(INTERVALO_PARTIDA)+1. contador never underflows.

Test Plan (defaults N=4, MAX=2, INTERVALO=100):
1. Reset held 3 cycles, pedido=0 → concessao=0000, qtd_ativas=0, ocupado=0, aguardando=0000.
2. pedido=1111 applied at cycle 0 → concessao=0001 after edge 1, concessao=0011 after edge 101, ocupado=1, aguardando=1100. No further change for 500 cycles.
3. From scenario 2, drop pedido[0] at cycle 300 → at edge 301 concessao=0110 (zone 0 released, zone 2 granted in the same edge), qtd_ativas stays 2, ponteiro=3.
4. Round-robin: MAX=2, pedido=1111 kept high; release and re-request each granted zone once it is granted → grant order 0,1,2,3,0,… and no zone is granted twice before all the others.
5. Withdrawal: pedido[3] pulsed high for 50 cycles while ocupado=1 → concessao[3] never asserts and aguardando[3] returns to 0.
6. desligar_tudo pulsed for 1 cycle at cycle 150 with 2 zones active → concessao=0000 at edge 151. The first regrant is no earlier than edge 251, and the next is 100 cycles after that. Repeat the run with rst instead of desligar_tudo → identical clear, but the first regrant occurs 1 edge after rst deasserts.
